// File: rtl/cpu_8bit_pkg.sv
// Shared definitions for the cpu_8bit core: opcodes, field widths, instruction layout and ALU.
package cpu_8bit_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_LDI = 2'b11;

    localparam int DATA_W = 8;
    localparam int REG_AW = 3;

    typedef struct packed {
        logic [1:0]        op;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs;
    } instr_t;

    // Returns {carry, result}; for LDI the rs field doubles as the 3-bit immediate.
    function automatic logic [DATA_W:0] aluExec(
        input logic [1:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [REG_AW-1:0] imm
    );
        logic [DATA_W:0] res;
        case (op)
            OP_ADD:  res = {1'b0, a} + {1'b0, b};
            OP_SUB:  res = {(a < b), a - b};
            OP_XOR:  res = {1'b0, a ^ b};
            default: res = {1'b0, {(DATA_W-REG_AW){1'b0}}, imm};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cpu_8bit_reg_file.sv
// 8x8 register file with two asynchronous read ports and one synchronous write port.
module reg_file_8x8
    import cpu_8bit_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              write_enable,
    input  logic [REG_AW-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [REG_AW-1:0] read_reg1,
    output logic [DATA_W-1:0] read_data1,
    input  logic [REG_AW-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data2
);

    logic [DATA_W-1:0] regs_q [0:(1<<REG_AW)-1];

    // Reset has priority over the write port so a mid-program reset drops the writeback.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < (1 << REG_AW); i++) begin
                regs_q[i] <= '0;
            end
        end else if (write_enable) begin
            regs_q[write_reg] <= write_data;
        end
    end

    assign read_data1 = regs_q[read_reg1];
    assign read_data2 = regs_q[read_reg2];

endmodule

// File: rtl/cpu_8bit.sv
// Single-cycle 8-bit CPU core: pc, decode, ALU and registered result/carry outputs.
// Defining CPU_ZERO_FLAG_EN adds a registered zero_flag output.
module cpu_8bit
    import cpu_8bit_pkg::*;
#(
    parameter INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset,
    output logic [DATA_W-1:0] result,
    output logic              carry_out
`ifdef CPU_ZERO_FLAG_EN
    ,
    output logic              zero_flag
`endif
);

    logic [DATA_W-1:0] instr_mem [0:255];

    logic [7:0]        pc_q, pc_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              carry_q, carry_d;
    instr_t            instr;
    logic [DATA_W-1:0] rdData, rsData;
    logic [DATA_W:0]   aluOut;

    assign instr  = instr_t'(instr_mem[pc_q]);
    assign aluOut = aluExec(instr.op, rdData, rsData, instr.rs);

    // Every instruction writes back, so the write port is permanently enabled.
    reg_file_8x8 reg_file (
        .clk          (clk),
        .reset        (reset),
        .write_enable (1'b1),
        .write_reg    (instr.rd),
        .write_data   (aluOut[DATA_W-1:0]),
        .read_reg1    (instr.rd),
        .read_data1   (rdData),
        .read_reg2    (instr.rs),
        .read_data2   (rsData)
    );

    always_comb begin
        pc_d     = pc_q + 8'd1;
        result_d = aluOut[DATA_W-1:0];
        carry_d  = aluOut[DATA_W];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q     <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    assign result    = result_q;
    assign carry_out = carry_q;

`ifdef CPU_ZERO_FLAG_EN
    logic zero_q, zero_d;

    assign zero_d = (aluOut[DATA_W-1:0] == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign zero_flag = zero_q;
`endif

endmodule

// File: tb/tb_cpu_8bit.sv
// Scoreboard bench for cpu_8bit: a behavioural model predicts each edge, a monitor compares on negedge.
module tb_cpu_8bit;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] result;
    logic       carry_out;
`ifdef CPU_ZERO_FLAG_EN
    logic       zero_flag;
`endif

    cpu_8bit dut (
        .clk       (clk),
        .reset     (reset),
        .result    (result),
        .carry_out (carry_out)
`ifdef CPU_ZERO_FLAG_EN
        ,
        .zero_flag (zero_flag)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         pc;
        int         res;
        int         carry;
        int         zero;
        logic [63:0] regs;
    } exp_t;

    exp_t expQ[$];
    int   memModel [0:255];
    int   regModel [0:7];
    int   pcModel, resModel, carryModel, zeroModel;
    int   checkCount = 0;
    int   passCount  = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Loads one word into both the reference copy and the DUT memory.
    task automatic loadWord(input int addr, input int value);
        memModel[addr] = value & 8'hFF;
        dut.instr_mem[addr] = 8'(value);
    endtask

    // Reference behaviour of one rising edge, in plain integer arithmetic.
    task automatic modelEdge(input logic rst);
        exp_t e;
        int op, rd, rs, a, b, r, c;
        if (!rst) begin
            pcModel = 0; resModel = 0; carryModel = 0; zeroModel = 0;
            for (int i = 0; i < 8; i++) regModel[i] = 0;
        end else begin
            op = memModel[pcModel] / 64;
            rd = (memModel[pcModel] / 8) % 8;
            rs = memModel[pcModel] % 8;
            a  = regModel[rd];
            b  = regModel[rs];
            if (op == 0) begin
                r = (a + b) % 256; c = (a + b) > 255 ? 1 : 0;
            end else if (op == 1) begin
                r = (a - b + 256) % 256; c = (a < b) ? 1 : 0;
            end else if (op == 2) begin
                r = a ^ b; c = 0;
            end else begin
                r = rs; c = 0;
            end
            regModel[rd] = r;
            resModel = r; carryModel = c; zeroModel = (r == 0) ? 1 : 0;
            pcModel = (pcModel + 1) % 256;
        end
        e.pc = pcModel; e.res = resModel; e.carry = carryModel; e.zero = zeroModel;
        for (int i = 0; i < 8; i++) e.regs[i*8 +: 8] = 8'(regModel[i]);
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic rst, input int cycles);
        for (int n = 0; n < cycles; n++) begin
            reset = rst;
            @(posedge clk);
            modelEdge(rst);
            #1;
        end
    endtask

    // Monitor: one expected entry per executed edge, compared away from the active edge.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            exp_t e;
            logic [63:0] actRegs;
            e = expQ.pop_front();
            actRegs = {dut.reg_file.regs_q[7], dut.reg_file.regs_q[6], dut.reg_file.regs_q[5],
                       dut.reg_file.regs_q[4], dut.reg_file.regs_q[3], dut.reg_file.regs_q[2],
                       dut.reg_file.regs_q[1], dut.reg_file.regs_q[0]};
            checkOutput("result", 64'(result), 64'(e.res));
            checkOutput("carry_out", 64'(carry_out), 64'(e.carry));
            checkOutput("pc", 64'(dut.pc_q), 64'(e.pc));
            checkOutput("regs", actRegs, e.regs);
`ifdef CPU_ZERO_FLAG_EN
            checkOutput("zero_flag", 64'(zero_flag), 64'(e.zero));
`endif
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Directed program: LDI, ADD, SUB borrow, XOR self, reload R2=0xFB, ADD self overflow.
        for (int i = 0; i < 256; i++) loadWord(i, $urandom_range(0, 255));
        loadWord(0, 8'hCD);
        loadWord(1, 8'hD3);
        loadWord(2, 8'h0A);
        loadWord(3, 8'h51);
        loadWord(4, 8'h92);
        loadWord(5, 8'hDD);
        loadWord(6, 8'h53);
        loadWord(7, 8'h12);
        applyStimulus(1'b0, 2);
        applyStimulus(1'b1, 8);

        // Mid-run reset at pc=3, then all-LDI R1,1 program across a pc wrap.
        applyStimulus(1'b0, 1);
        applyStimulus(1'b1, 3);
        applyStimulus(1'b0, 1);
        for (int i = 0; i < 256; i++) loadWord(i, 8'hC9);
        applyStimulus(1'b1, 260);

        // Random program with occasional resets.
        applyStimulus(1'b0, 1);
        for (int i = 0; i < 256; i++) loadWord(i, $urandom_range(0, 255));
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1, 1);
        end

        for (int n = 0; n < 4 && expQ.size() > 0; n++) @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            checkCount++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
        end
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
